// File: rtl/seg7_pkg.sv
// Shared segment patterns (active-low {g,f,e,d,c,b,a}) and the digit-code type
// for the multiplexed 7-segment driver.
package seg7_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low segment lookup.
// Define SEG7_HEX_DIGITS_EN to show codes A-F as hex letters; otherwise they are blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef SEG7_HEX_DIGITS_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with tear-free frame
// updates and an anodes-off guard at each slot start. Hex letters via SEG7_HEX_DIGITS_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PSC_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PSC_W:0]   GUARD_V  = (PSC_W + 1)'(GUARD_CYCLES);

  logic [PSC_W-1:0]        psc;
  logic [IDX_W-1:0]        idx;
  logic                    pending;
  logic [4*NUM_DIGITS-1:0] staging;
  logic [NUM_DIGITS-1:0]   staging_dp;
  logic [4*NUM_DIGITS-1:0] disp;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic tick;
  logic wrap;

  assign tick = en && (psc == PSC_LAST);
  assign wrap = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc <= '0;
      idx <= '0;
    end else if (tick) begin
      psc <= '0;
      idx <= wrap ? '0 : idx + 1'b1;
    end else if (en) begin
      psc <= psc + 1'b1;
    end
  end

  // Display only changes on the frame wrap, so a frame never mixes old and new digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= 1'b0;
      staging    <= '0;
      staging_dp <= '0;
      disp       <= '1;
      disp_dp    <= '0;
    end else if (wrap) begin
      if (load) begin
        disp    <= bcd_in;
        disp_dp <= dp_in;
      end else if (pending) begin
        disp    <= staging;
        disp_dp <= staging_dp;
      end
      pending <= 1'b0;
    end else if (load) begin
      staging    <= bcd_in;
      staging_dp <= dp_in;
      pending    <= 1'b1;
    end
  end

  // Stage p0: select current digit and decide lit vs. guard/idle
  digit_t                cur_digit_p0;
  logic [6:0]            cur_seg_p0;
  logic                  vld_p0;
  logic [NUM_DIGITS-1:0] an_p0;

  assign cur_digit_p0 = disp[{idx, 2'b00} +: 4];
  assign vld_p0       = en && ({1'b0, psc} >= GUARD_V);

  seg7_decode u_decode (
    .code (cur_digit_p0),
    .seg  (cur_seg_p0)
  );

  always_comb begin
    an_p0      = '1;
    an_p0[idx] = 1'b0;
  end

  // Stage p1: registered pin drivers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_OFF;
      dp         <= 1'b1;
      an         <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (vld_p0) begin
        seg <= cur_seg_p0;
        dp  <= ~disp_dp[idx];
        an  <= an_p0;
      end else begin
        seg <= SEG_OFF;
        dp  <= 1'b1;
        an  <= '1;
      end
    end
  end

endmodule
